// File: rtl/adc_stream_pkg.sv
// Shared types and helpers for the per-channel ADC stream controller.
package adc_stream_pkg;

    localparam int WORD_BYTES = 4;
    localparam int REQ_AW     = 12;
    localparam int REQ_DW     = 32;
    localparam int REQ_CW     = 4;

    typedef struct packed {
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] data;
        logic [REQ_CW-1:0] chid;
        logic              last;
        logic              half;
    } adc_req_t;

    function automatic logic [REQ_CW-1:0] get_chid(input logic [REQ_DW-1:0] smp, input int lsb);
        return smp[lsb +: REQ_CW];
    endfunction

endpackage

// File: rtl/adc_ch_ptr_type1.sv
// One channel's run state, ring-buffer write pointer and decimation counter.
module adc_ch_ptr_type1
    import adc_stream_pkg::*;
#(
    parameter int TRANS_SIZE  = 16,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_en_i,
    input  logic                   cfg_clr_i,
    input  logic [TRANS_SIZE-1:0]  cfg_size_i,
    input  logic                   cfg_continuous_i,
    input  logic [DECIM_WIDTH-1:0] cfg_decim_i,
    input  logic                   smp_hit_i,
    input  logic                   accept_i,
    output logic                   en_o,
    output logic [TRANS_SIZE-1:0]  wr_ptr_o,
    output logic                   keep_o,
    output logic                   half_o,
    output logic                   last_o
);

    localparam logic [TRANS_SIZE-1:0] WORD_B = TRANS_SIZE'(WORD_BYTES);

    logic [DECIM_WIDTH-1:0] decim_cnt;
    logic [TRANS_SIZE-1:0]  ptr_next;
    logic [TRANS_SIZE-1:0]  half_thr;

    // A 4-byte buffer has a zero half threshold; treat its only word as the half word too.
    always_comb begin
        ptr_next = wr_ptr_o + WORD_B;
        half_thr = (cfg_size_i >> 1) & ~(WORD_B - 1'b1);
        if (half_thr == '0) begin
            half_thr = WORD_B;
        end
    end

    assign keep_o = (decim_cnt == '0);
    assign half_o = (ptr_next == half_thr);
    assign last_o = (ptr_next == cfg_size_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_o      <= 1'b0;
            wr_ptr_o  <= '0;
            decim_cnt <= '0;
        end else if (cfg_clr_i) begin
            en_o     <= 1'b0;
            wr_ptr_o <= '0;
        end else if (cfg_en_i) begin
            en_o      <= (cfg_size_i >= WORD_B);
            wr_ptr_o  <= '0;
            decim_cnt <= cfg_decim_i;
        end else begin
            if (smp_hit_i) begin
                decim_cnt <= keep_o ? cfg_decim_i : decim_cnt - 1'b1;
            end
            if (accept_i) begin
                wr_ptr_o <= last_o ? '0 : ptr_next;
                if (last_o && !cfg_continuous_i) begin
                    en_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/adc_ch_stream_type1.sv
// Per-channel ADC stream controller: decode, decimate, address and hand samples to uDMA.
module adc_ch_stream_type1
    import adc_stream_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = 32,
    parameter int NUM_CHS        = 16,
    parameter int CH_ID_LSB      = 28,
    parameter int CH_ID_WIDTH    = 4,
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int DECIM_WIDTH    = 8,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              smp_valid_i,
    input  logic [ADC_DATA_WIDTH-1:0]         smp_data_i,
    input  logic [NUM_CHS*L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
    input  logic [NUM_CHS*TRANS_SIZE-1:0]     cfg_size_i,
    input  logic [NUM_CHS-1:0]                cfg_continuous_i,
    input  logic [NUM_CHS*DECIM_WIDTH-1:0]    cfg_decim_i,
    input  logic [NUM_CHS-1:0]                cfg_en_i,
    input  logic [NUM_CHS-1:0]                cfg_clr_i,
    output logic [NUM_CHS-1:0]                ch_en_o,
    output logic [NUM_CHS*TRANS_SIZE-1:0]     ch_wr_ptr_o,
    output logic                              req_valid_o,
    input  logic                              req_ready_i,
    output logic [L2_AWIDTH_NOAL-1:0]         req_addr_o,
    output logic [ADC_DATA_WIDTH-1:0]         req_data_o,
    output logic [CH_ID_WIDTH-1:0]            req_chid_o,
    output logic [NUM_CHS-1:0]                ch_event_o,
    output logic [NUM_CHS-1:0]                half_event_o,
    output logic [DROP_CNT_WIDTH-1:0]         drop_cnt_o,
    input  logic                              drop_cnt_clr_i
);

    logic [CH_ID_WIDTH-1:0] chid;
    logic                   chid_ok;
    logic [NUM_CHS-1:0]     hit;
    logic [NUM_CHS-1:0]     keep;
    logic [NUM_CHS-1:0]     half;
    logic [NUM_CHS-1:0]     last;
    logic [NUM_CHS-1:0]     accept;
    logic [TRANS_SIZE-1:0]  ptr [NUM_CHS];

    adc_req_t req_q;
    adc_req_t req_d;
    logic     req_vld;
    logic     handshake;
    logic     flush;
    logic     free;
    logic     kept;
    logic     drop_inc;

    assign chid    = CH_ID_WIDTH'(get_chid(REQ_DW'(smp_data_i), CH_ID_LSB));
    assign chid_ok = 32'(chid) < NUM_CHS;

    // A channel seeing en or clr this cycle ignores the sample; the config action wins.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CHS; i++) begin
            hit[i] = smp_valid_i && chid_ok && (32'(chid) == i) && ch_en_o[i]
                     && !cfg_en_i[i] && !cfg_clr_i[i];
        end
    end

    always_comb begin
        flush = 1'b0;
        for (int i = 0; i < NUM_CHS; i++) begin
            if (req_vld && cfg_clr_i[i] && (32'(req_q.chid) == i)) begin
                flush = 1'b1;
            end
        end
    end

    assign handshake = req_vld && req_ready_i;
    assign free      = !req_vld || handshake || flush;
    assign kept      = |(hit & keep);
    assign accept    = (hit & keep) & {NUM_CHS{free}};
    assign drop_inc  = kept && !free;

    always_comb begin
        req_d = req_q;
        for (int i = 0; i < NUM_CHS; i++) begin
            if (hit[i]) begin
                req_d.addr = REQ_AW'(cfg_startaddr_i[i*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]
                                     + L2_AWIDTH_NOAL'(ptr[i]));
                req_d.data = REQ_DW'(smp_data_i);
                req_d.chid = REQ_CW'(chid);
                req_d.last = last[i];
                req_d.half = half[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CHS; g++) begin : g_ch
        adc_ch_ptr_type1 #(
            .TRANS_SIZE  (TRANS_SIZE),
            .DECIM_WIDTH (DECIM_WIDTH)
        ) u_ptr (
            .clk_i            (clk_i),
            .rst_i            (rst_i),
            .cfg_en_i         (cfg_en_i[g]),
            .cfg_clr_i        (cfg_clr_i[g]),
            .cfg_size_i       (cfg_size_i[g*TRANS_SIZE +: TRANS_SIZE]),
            .cfg_continuous_i (cfg_continuous_i[g]),
            .cfg_decim_i      (cfg_decim_i[g*DECIM_WIDTH +: DECIM_WIDTH]),
            .smp_hit_i        (hit[g]),
            .accept_i         (accept[g]),
            .en_o             (ch_en_o[g]),
            .wr_ptr_o         (ptr[g]),
            .keep_o           (keep[g]),
            .half_o           (half[g]),
            .last_o           (last[g])
        );
        assign ch_wr_ptr_o[g*TRANS_SIZE +: TRANS_SIZE] = ptr[g];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_vld <= 1'b0;
            req_q   <= '0;
        end else if (|accept) begin
            req_vld <= 1'b1;
            req_q   <= req_d;
        end else if (handshake || flush) begin
            req_vld <= 1'b0;
        end
    end

    // A request flushed by clr in its handshake cycle emits no events.
    always_comb begin
        ch_event_o   = '0;
        half_event_o = '0;
        for (int i = 0; i < NUM_CHS; i++) begin
            if (handshake && !flush && (32'(req_q.chid) == i)) begin
                ch_event_o[i]   = req_q.last;
                half_event_o[i] = req_q.half;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_o <= '0;
        end else if (drop_cnt_clr_i) begin
            drop_cnt_o <= '0;
        end else if (drop_inc && !(&drop_cnt_o)) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

    assign req_valid_o = req_vld;
    assign req_addr_o  = L2_AWIDTH_NOAL'(req_q.addr);
    assign req_data_o  = ADC_DATA_WIDTH'(req_q.data);
    assign req_chid_o  = CH_ID_WIDTH'(req_q.chid);

endmodule
